// File: rtl/timer_bank.sv
// Bank of NUM_CH tick counters, each pulsing done for one clk after L qualified ticks (one-shot or periodic).
// done/busy/expired follow one clk after the causing input; rd_count lags rd_sel by one clk; no backpressure.
module timer_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 24,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    tick,
    input  logic                    pause,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*WIDTH-1:0] limit,
    input  logic [SEL_W-1:0]        rd_sel,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expired,
    output logic [WIDTH-1:0]        rd_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    typedef struct packed {
        state_t           st;
        logic             per;
        logic [WIDTH-1:0] lim;
        logic [WIDTH-1:0] cnt;
    } chan_t;

    chan_t             ch [NUM_CH];
    logic              qual_tick;
    logic [NUM_CH-1:0] last;
    logic [WIDTH-1:0]  rd_nxt;

    assign qual_tick = tick & ~pause;

    // A latched limit of 0 behaves like 1: every qualified tick is terminal.
    always_comb begin
        last    = '0;
        busy    = '0;
        expired = '0;
        rd_nxt  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            last[i]    = (ch[i].lim == '0) || (ch[i].cnt == ch[i].lim - WIDTH'(1));
            busy[i]    = (ch[i].st == RUN);
            expired[i] = (ch[i].st == EXPIRED);
            if (rd_sel == SEL_W'(i))
                rd_nxt = ch[i].cnt;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch[i].st  <= IDLE;
                ch[i].per <= 1'b0;
                ch[i].lim <= '0;
                ch[i].cnt <= '0;
            end
            done     <= '0;
            rd_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                done[i] <= 1'b0;
                if (stop[i]) begin
                    ch[i].st  <= IDLE;
                    ch[i].cnt <= '0;
                end else if (start[i]) begin
                    ch[i].st  <= RUN;
                    ch[i].cnt <= '0;
                    ch[i].lim <= limit[i*WIDTH +: WIDTH];
                    ch[i].per <= periodic[i];
                end else if (ch[i].st == RUN && qual_tick) begin
                    if (last[i]) begin
                        ch[i].cnt <= '0;
                        done[i]   <= 1'b1;
                        if (!ch[i].per)
                            ch[i].st <= EXPIRED;
                    end else begin
                        ch[i].cnt <= ch[i].cnt + WIDTH'(1);
                    end
                end
            end
            rd_count <= rd_nxt;
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Randomised and directed bench for timer_bank against a tick-counting reference model.
module tb_timer_bank;
    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           resetN = 1'b0;
    logic           tick = 1'b0;
    logic           pause = 1'b0;
    logic [N-1:0]   start = '0;
    logic [N-1:0]   stop = '0;
    logic [N-1:0]   periodic = '0;
    logic [N*W-1:0] limit = '0;
    logic [S-1:0]   rd_sel = '0;
    logic [N-1:0]   done, busy, expired;
    logic [W-1:0]   rd_count;

    timer_bank #(.NUM_CH(N), .WIDTH(W), .SEL_W(S)) dut (
        .clk(clk), .resetN(resetN), .tick(tick), .pause(pause),
        .start(start), .stop(stop), .periodic(periodic), .limit(limit),
        .rd_sel(rd_sel), .done(done), .busy(busy), .expired(expired),
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: ticks seen since start or last terminal, the effective period, and mode flags.
    int           m_seen [N];
    int           m_len  [N];
    logic [N-1:0] m_per, m_run, m_exp, m_done;
    logic [W-1:0] m_rd;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_seen[i] = 0;
            m_len[i]  = 1;
        end
        m_per = '0; m_run = '0; m_exp = '0; m_done = '0; m_rd = '0;
    endtask

    task automatic model_clock();
        int lv;
        m_rd = (int'(rd_sel) < N) ? W'(m_seen[int'(rd_sel)]) : '0;
        for (int i = 0; i < N; i++) begin
            m_done[i] = 1'b0;
            if (stop[i]) begin
                m_run[i] = 1'b0; m_exp[i] = 1'b0; m_seen[i] = 0;
            end else if (start[i]) begin
                lv = int'(limit[i*W +: W]);
                m_len[i] = (lv == 0) ? 1 : lv;
                m_per[i] = periodic[i];
                m_run[i] = 1'b1; m_exp[i] = 1'b0; m_seen[i] = 0;
            end else if (m_run[i] && tick && !pause) begin
                m_seen[i] = m_seen[i] + 1;
                if (m_seen[i] == m_len[i]) begin
                    m_seen[i] = 0;
                    m_done[i] = 1'b1;
                    if (!m_per[i]) begin
                        m_run[i] = 1'b0; m_exp[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (resetN) model_clock();
        @(negedge clk);
    endtask

    task automatic set_lim(input int c, input int v);
        limit[c*W +: W] = W'(v);
    endtask

    task automatic clear_all();
        tick = 0; pause = 0; start = '0; stop = '1;
        cyc();
        stop = '0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #1;
        if ({done, busy, expired, rd_count} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b/%b/%b/%0d want all zero", done, busy, expired, rd_count);
        end
        tests++;
        @(negedge clk);
        resetN = 1'b1;
        tick = 1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            if ({done, busy, expired, rd_count} !== {m_done, m_run, m_exp, m_rd}) begin
                fails++;
                $display("FAIL reset_idle_ticks c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         done, busy, expired, rd_count, m_done, m_run, m_exp, m_rd);
            end
            tests++;
        end
        tick = 0;
    endtask

    task automatic test_oneshot();
        int np = 0;
        clear_all();
        set_lim(0, 5); periodic[0] = 0; rd_sel = 0; start[0] = 1;
        cyc();
        start = '0;
        for (int c = 0; c < 30; c++) begin
            tick = (c % 3 == 2);
            cyc();
            if (done[0]) np++;
            if ({done, busy, expired, rd_count} !== {m_done, m_run, m_exp, m_rd}) begin
                fails++;
                $display("FAIL oneshot c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         done, busy, expired, rd_count, m_done, m_run, m_exp, m_rd);
            end
            tests++;
        end
        tick = 0;
        if (np !== 1 || expired[0] !== 1'b1 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL oneshot_summary: pulses=%0d exp=%b busy=%b want 1/1/0", np, expired[0], busy[0]);
        end
        tests++;
    endtask

    task automatic test_periodic();
        int np = 0;
        clear_all();
        set_lim(1, 3); periodic[1] = 1; rd_sel = 1; start[1] = 1;
        cyc();
        start = '0; tick = 1;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (done[1]) np++;
            if ({done, busy, expired, rd_count} !== {m_done, m_run, m_exp, m_rd}) begin
                fails++;
                $display("FAIL periodic c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         done, busy, expired, rd_count, m_done, m_run, m_exp, m_rd);
            end
            tests++;
        end
        tick = 0;
        if (np !== 4 || busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL periodic_summary: pulses=%0d busy=%b want 4/1", np, busy[1]);
        end
        tests++;
    endtask

    task automatic test_pause_limit0();
        int np = 0;
        clear_all();
        set_lim(2, 4); periodic[2] = 0; rd_sel = 2; start[2] = 1;
        cyc();
        start = '0;
        for (int c = 0; c < 16; c++) begin
            tick = 1;
            pause = (c >= 2 && c < 12);
            cyc();
            if (done[2]) np++;
            if ({done, busy, expired, rd_count} !== {m_done, m_run, m_exp, m_rd}) begin
                fails++;
                $display("FAIL pause c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         done, busy, expired, rd_count, m_done, m_run, m_exp, m_rd);
            end
            tests++;
            if (c == 12 && np !== 0) begin
                fails++;
                $display("FAIL pause_early_done: pulses=%0d want 0 after 3 live ticks", np);
            end
            if (c == 12) tests++;
        end
        if (np !== 1) begin
            fails++;
            $display("FAIL pause_pulses: got %0d want 1", np);
        end
        tests++;
        clear_all();
        np = 0;
        set_lim(3, 0); periodic[3] = 1; start[3] = 1;
        cyc();
        start = '0; tick = 1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (done[3]) np++;
        end
        tick = 0;
        if (np !== 5) begin
            fails++;
            $display("FAIL limit0_pulses: got %0d want 5", np);
        end
        tests++;
    endtask

    task automatic test_restart_stop();
        int np = 0;
        clear_all();
        set_lim(0, 5); periodic[0] = 0; rd_sel = 0; start[0] = 1;
        cyc();
        start = '0; tick = 1;
        repeat (3) cyc();
        start[0] = 1;
        cyc();
        start = '0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (done[0]) np++;
            if (c == 3 && np !== 0) begin
                fails++;
                $display("FAIL restart_early: pulses=%0d want 0 after 4 ticks", np);
            end
            if (c == 3) tests++;
        end
        if (np !== 1 || done[0] !== 1'b1) begin
            fails++;
            $display("FAIL restart_done: pulses=%0d done=%b want 1/1", np, done[0]);
        end
        tests++;
        start[0] = 1; stop[0] = 1;
        cyc();
        start = '0; stop = '0;
        if (busy[0] !== 1'b0 || expired[0] !== 1'b0) begin
            fails++;
            $display("FAIL start_stop_same: busy=%b exp=%b want 0/0", busy[0], expired[0]);
        end
        tests++;
        set_lim(0, 2); start[0] = 1;
        cyc();
        start = '0;
        cyc();
        stop[0] = 1;
        cyc();
        stop = '0; tick = 0;
        if ({done[0], busy[0], expired[0]} !== 3'b000) begin
            fails++;
            $display("FAIL stop_terminal: done/busy/exp=%b want 000", {done[0], busy[0], expired[0]});
        end
        tests++;
    endtask

    task automatic test_concurrency();
        int n0 = 0, nb = 0;
        clear_all();
        set_lim(0, 2); set_lim(1, 4); periodic = 4'b0011; start = 4'b0011;
        cyc();
        start = '0; tick = 1;
        for (int c = 0; c < 16; c++) begin
            cyc();
            if (done[0]) n0++;
            if (done[0] && done[1]) nb++;
            if ({done, busy, expired} !== {m_done, m_run, m_exp}) begin
                fails++;
                $display("FAIL concurrency c%0d: got %b/%b/%b want %b/%b/%b", c,
                         done, busy, expired, m_done, m_run, m_exp);
            end
            tests++;
        end
        tick = 0;
        if (n0 !== 8 || nb !== 4) begin
            fails++;
            $display("FAIL concurrency_counts: done0=%0d both=%0d want 8/4", n0, nb);
        end
        tests++;
    endtask

    task automatic test_max_limit();
        int np = 0;
        clear_all();
        set_lim(2, 255); periodic[2] = 0; rd_sel = 2; start[2] = 1;
        cyc();
        start = '0; tick = 1;
        for (int c = 0; c < 256; c++) begin
            cyc();
            if (done[2]) np++;
            if (c == 253 && rd_count !== 8'd253) begin
                fails++;
                $display("FAIL max_count: got %0d want 253", rd_count);
            end
            if (c == 253) tests++;
        end
        tick = 0;
        if (np !== 1 || expired[2] !== 1'b1) begin
            fails++;
            $display("FAIL max_limit: pulses=%0d exp=%b want 1/1", np, expired[2]);
        end
        tests++;
    endtask

    task automatic test_random();
        clear_all();
        for (int c = 0; c < 3000; c++) begin
            tick  = ($urandom_range(0, 2) != 0);
            pause = ($urandom_range(0, 7) == 0);
            rd_sel = S'($urandom_range(0, 5));
            for (int i = 0; i < N; i++) begin
                start[i] = ($urandom_range(0, 19) == 0);
                stop[i]  = ($urandom_range(0, 59) == 0);
                periodic[i] = $urandom_range(0, 1);
                set_lim(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6));
            end
            cyc();
            if ({done, busy, expired, rd_count} !== {m_done, m_run, m_exp, m_rd}) begin
                fails++;
                $display("FAIL random c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         done, busy, expired, rd_count, m_done, m_run, m_exp, m_rd);
            end
            tests++;
        end
        start = '0; stop = '0; tick = 0; pause = 0;
    endtask

    task automatic test_reset_midrun();
        clear_all();
        set_lim(3, 20); periodic[3] = 1; rd_sel = 3; start[3] = 1;
        cyc();
        start = '0; tick = 1;
        repeat (7) cyc();
        tick = 0;
        cyc();
        if (rd_count !== 8'd7 || busy[3] !== 1'b1) begin
            fails++;
            $display("FAIL midrun_pre: count=%0d busy=%b want 7/1", rd_count, busy[3]);
        end
        tests++;
        #2 resetN = 1'b0;
        #1;
        if ({done, busy, expired, rd_count} !== '0) begin
            fails++;
            $display("FAIL midrun_async: got %b/%b/%b/%0d want all zero", done, busy, expired, rd_count);
        end
        tests++;
        model_reset();
        @(negedge clk);
        resetN = 1'b1; tick = 1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if ({done, busy, expired, rd_count} !== {m_done, m_run, m_exp, m_rd}) begin
                fails++;
                $display("FAIL midrun_after c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", c,
                         done, busy, expired, rd_count, m_done, m_run, m_exp, m_rd);
            end
            tests++;
        end
        tick = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause_limit0();
        test_restart_stop();
        test_concurrency();
        test_max_limit();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
Bank of NUM_CH independent programmable tick counters for game timing: ball speed steps, power-up duration, bonus blink and level countdown. Each channel counts qualified ticks up to a limit latched at start, then emits a one-cycle done pulse. It runs in one-shot or periodic mode. A global pause freezes all channels, and a read port exposes any channel's live count.

Parameters:
NUM_CH, 4, number of independent timer channels (1..16)
WIDTH, 24, counter and limit width in bits
SEL_W, 2, width of rd_sel; must satisfy 2**SEL_W >= NUM_CH

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
tick  in  1  count strobe (e.g. 1 ms enable); one cycle wide, sampled each clk
pause  in  1  global freeze of all channels while high
start  in  NUM_CH  per-channel start/restart request, one cycle
stop  in  NUM_CH  per-channel abort request, one cycle
periodic  in  NUM_CH  per-channel mode, sampled at start: 1 = periodic, 0 = one-shot
limit  in  NUM_CH*WIDTH  per-channel period in ticks; channel i uses bits [i*WIDTH +: WIDTH], sampled at start
rd_sel  in  SEL_W  channel index for rd_count
done  out  NUM_CH  one-cycle pulse per channel at terminal count
busy  out  NUM_CH  channel in RUN state
expired  out  NUM_CH  sticky flag: one-shot channel finished
rd_count  out  WIDTH  registered current count of channel rd_sel

Behaviour:
- Reset (async, resetN=0): all channels go to IDLE. Outputs on reset: count=0, latched limit=0, latched mode=0, done=0, busy=0, expired=0, rd_count=0. Reset mid-run aborts immediately and emits no done.
- Per-channel FSM states: IDLE, RUN, EXPIRED. busy=1 only in RUN; expired=1 only in EXPIRED.
- Qualified tick: tick=1 AND pause=0 AND state=RUN.
- Start (any state): next cycle the channel is in RUN with count=0, and limit[i] and periodic[i] are latched. A start while in RUN is a restart with no done pulse. A start in EXPIRED clears expired.
- Stop: next cycle the channel is in IDLE with count=0 and no done pulse. Stop and start in the same cycle: stop wins.
- Counting: on a qualified tick with count != L-1, count <= count+1. L is the latched limit; a latched limit of 0 is treated as 1.
- Terminal: on a qualified tick with count == L-1, the next cycle gives done[i]=1 for exactly one clk and count=0.
  - Periodic: stay in RUN. The period is exactly L qualified ticks.
  - One-shot: go to EXPIRED.
- done is registered, so it rises one clk after the terminal tick cycle. A start or stop in the terminal tick cycle overrides: no done pulse.
- Pause: count, state and latched values are frozen. A tick during pause is lost, not deferred. start and stop still act during pause.
- Ticks in IDLE or EXPIRED are ignored, and count stays 0.
- Arithmetic: unsigned WIDTH bits. count never exceeds L-1, so no wrap beyond L-1 is possible. L = 2**WIDTH-1 is legal.
- Channels are fully independent. Terminal events on several channels in the same cycle all pulse done together.
- rd_count: registered mux of count[rd_sel], 1-cycle latency. An out-of-range rd_sel returns 0.

Test Plan:
- One-shot: limit0=5, periodic0=0, start0, tick every 3rd clk -> done0 pulses once, 1 clk after the 5th tick. Then expired0=1 and busy0=0; further ticks give no done.
- Periodic: limit1=3, periodic1=1, tick every clk for 12 clks -> done1 pulses 4 times, every 3 clks. busy1 stays 1; rd_sel=1 shows 0,1,2,0,... with 1-clk lag.
- Pause and limit 0: limit2=4, run 2 ticks, pause for 10 tick-cycles, then release -> done2 only after 2 more ticks. Separately, limit=0 periodic -> done on every qualified tick.
- Restart/stop precedence: restart ch0 at count 3 of limit 5 -> no done, count=0, 5 more ticks needed. start0 and stop0 in the same cycle -> IDLE, busy0=0. A stop in the terminal tick cycle -> no done.
- Reset mid-run: assert resetN=0 asynchronously with channel 3 in RUN at count 7 -> all outputs 0 immediately. After release, ticks cause no activity until start.
- Concurrency: ch0 limit=2 and ch1 limit=4, both periodic, started together -> done0 and done1 coincide every 4th tick. No cross-channel interference.
